// File: rtl/spell_mem_initiator.sv
// Spell memory bus initiator: arbitrates fetch vs. load/store, runs one bus access at a
// time with a bounded wait on the responder, and returns a registered response.
module spell_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fetch_valid,
  input  logic [7:0] fetch_addr,
  output logic       fetch_ready,
  input  logic       dreq_valid,
  input  logic       dreq_write,
  input  logic       dreq_code,
  input  logic [7:0] dreq_addr,
  input  logic [7:0] dreq_wdata,
  output logic       dreq_ready,
  output logic       resp_valid,
  output logic       resp_port,
  output logic [7:0] resp_rdata,
  output logic       resp_error,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic [1:0] mem_memory_type,
  output logic       mem_write,
  input  logic [7:0] mem_rdata,
  input  logic       mem_data_ready
);

  localparam logic [1:0] MemoryTypeData = 2'd1;
  localparam logic [1:0] MemoryTypeCode = 2'd2;
  localparam logic [7:0] TimeoutLimit   = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

  state_e     state_q, state_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       last_dreq_q, last_dreq_d;
  logic       port_q, port_d;
  logic       mem_select_q, mem_select_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic [1:0] mem_type_q, mem_type_d;
  logic       mem_write_q, mem_write_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_port_q, resp_port_d;
  logic [7:0] resp_rdata_q, resp_rdata_d;
  logic       resp_error_q, resp_error_d;
  logic       grant_fetch, grant_dreq;

  // Round-robin on ties: the port that lost the previous grant wins.
  always_comb begin
    grant_fetch = 1'b0;
    grant_dreq  = 1'b0;
    if (state_q == StIdle && !reset) begin
      if (fetch_valid && dreq_valid) begin
        grant_dreq  = !last_dreq_q;
        grant_fetch = last_dreq_q;
      end else begin
        grant_fetch = fetch_valid;
        grant_dreq  = dreq_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    last_dreq_d  = last_dreq_q;
    port_d       = port_q;
    mem_select_d = mem_select_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_type_d   = mem_type_q;
    mem_write_d  = mem_write_q;
    resp_valid_d = 1'b0;
    resp_port_d  = resp_port_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      StIdle: begin
        if (grant_dreq) begin
          mem_select_d = 1'b1;
          mem_addr_d   = dreq_addr;
          mem_wdata_d  = dreq_wdata;
          mem_write_d  = dreq_write;
          mem_type_d   = dreq_code ? MemoryTypeCode : MemoryTypeData;
          port_d       = 1'b1;
          last_dreq_d  = 1'b1;
          tmo_cnt_d    = 8'd0;
          state_d      = StAccess;
        end else if (grant_fetch) begin
          mem_select_d = 1'b1;
          mem_addr_d   = fetch_addr;
          mem_wdata_d  = 8'd0;
          mem_write_d  = 1'b0;
          mem_type_d   = MemoryTypeCode;
          port_d       = 1'b0;
          last_dreq_d  = 1'b0;
          tmo_cnt_d    = 8'd0;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (mem_data_ready) begin
          mem_select_d = 1'b0;
          resp_valid_d = 1'b1;
          resp_port_d  = port_q;
          resp_error_d = 1'b0;
          resp_rdata_d = mem_write_q ? 8'd0 : mem_rdata;
          state_d      = StRelease;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_q + 8'd1 == TimeoutLimit) begin
            mem_select_d = 1'b0;
            resp_valid_d = 1'b1;
            resp_port_d  = port_q;
            resp_error_d = 1'b1;
            resp_rdata_d = 8'd0;
            state_d      = StRelease;
          end
        end
      end
      StRelease: begin
        // Wait for the responder to drop data_ready, absorbing late or sticky ready.
        if (!mem_data_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      tmo_cnt_q    <= 8'd0;
      last_dreq_q  <= 1'b0;
      port_q       <= 1'b0;
      mem_select_q <= 1'b0;
      mem_addr_q   <= 8'd0;
      mem_wdata_q  <= 8'd0;
      mem_type_q   <= 2'd0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_rdata_q <= 8'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      last_dreq_q  <= last_dreq_d;
      port_q       <= port_d;
      mem_select_q <= mem_select_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_type_q   <= mem_type_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign fetch_ready     = grant_fetch;
  assign dreq_ready      = grant_dreq;
  assign mem_select      = mem_select_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_memory_type = mem_type_q;
  assign mem_write       = mem_write_q;
  assign resp_valid      = resp_valid_q;
  assign resp_port       = resp_port_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_error      = resp_error_q;

endmodule

// File: tb/tb_spell_mem_initiator.sv
// Directed bench for spell_mem_initiator with a behavioural responder (latency, dead and
// sticky-ready modes).
module tb_spell_mem_initiator;

  localparam logic [1:0] MemTypeData = 2'd1;
  localparam logic [1:0] MemTypeCode = 2'd2;

  logic       clock = 1'b0;
  logic       reset;
  logic       fetch_valid;
  logic [7:0] fetch_addr;
  logic       fetch_ready;
  logic       dreq_valid;
  logic       dreq_write;
  logic       dreq_code;
  logic [7:0] dreq_addr;
  logic [7:0] dreq_wdata;
  logic       dreq_ready;
  logic       resp_valid;
  logic       resp_port;
  logic [7:0] resp_rdata;
  logic       resp_error;
  logic       mem_select;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [1:0] mem_memory_type;
  logic       mem_write;
  logic [7:0] mem_rdata;
  logic       mem_data_ready;

  always #5 clock = ~clock;

  spell_mem_initiator #(
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_valid    (fetch_valid),
    .fetch_addr     (fetch_addr),
    .fetch_ready    (fetch_ready),
    .dreq_valid     (dreq_valid),
    .dreq_write     (dreq_write),
    .dreq_code      (dreq_code),
    .dreq_addr      (dreq_addr),
    .dreq_wdata     (dreq_wdata),
    .dreq_ready     (dreq_ready),
    .resp_valid     (resp_valid),
    .resp_port      (resp_port),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_select     (mem_select),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_memory_type(mem_memory_type),
    .mem_write      (mem_write),
    .mem_rdata      (mem_rdata),
    .mem_data_ready (mem_data_ready)
  );

  // Responder model
  logic [7:0] code_mem [256];
  logic [7:0] data_mem [256];
  int         latency = 4;
  int         sticky_hold = 0;
  bit         dead = 1'b0;
  int         lat_cnt;
  int         sticky_cnt;

  always @(posedge clock) begin
    if (reset) begin
      mem_data_ready     <= 1'b0;
      mem_rdata          <= 8'd0;
      lat_cnt            <= 0;
      sticky_cnt         <= 0;
      code_mem[8'h10]    <= 8'hA5;
      code_mem[8'h20]    <= 8'h33;
    end else if (mem_data_ready) begin
      if (!mem_select) begin
        if (sticky_cnt >= sticky_hold) begin
          mem_data_ready <= 1'b0;
          sticky_cnt     <= 0;
        end else begin
          sticky_cnt <= sticky_cnt + 1;
        end
      end
    end else if (mem_select && !dead) begin
      if (lat_cnt >= latency - 1) begin
        mem_data_ready <= 1'b1;
        lat_cnt        <= 0;
        if (mem_write) begin
          mem_rdata <= 8'd0;
          if (mem_memory_type == MemTypeCode) code_mem[mem_addr] <= mem_wdata;
          else data_mem[mem_addr] <= mem_wdata;
        end else begin
          mem_rdata <= (mem_memory_type == MemTypeCode) ? code_mem[mem_addr] : data_mem[mem_addr];
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  // Protocol monitors
  int resp_cnt = 0;
  int viol_both = 0;
  int viol_busy = 0;

  always @(negedge clock) begin
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (fetch_ready && dreq_ready) viol_both <= viol_both + 1;
      if ((fetch_ready || dreq_ready) && mem_select) viol_busy <= viol_busy + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the low phase; returns #1 after the granting edge.
  task automatic wait_grant(output bit got_f, output bit got_d);
    int n = 0;
    #1;
    while (!fetch_ready && !dreq_ready && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    got_f = fetch_ready;
    got_d = dreq_ready;
    if (!got_f && !got_d) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  // Returns at the negedge where resp_valid is seen; counts select-high cycles before it.
  task automatic wait_resp(output int sel_cycles);
    sel_cycles = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (resp_valid) break;
      if (mem_select) sel_cycles++;
    end
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  bit gf, gd;
  int sel;
  int base;
  int rdy_cycles;
  int bad;

  initial begin
    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_addr  = 8'd0;
    dreq_valid  = 1'b0;
    dreq_write  = 1'b0;
    dreq_code   = 1'b0;
    dreq_addr   = 8'd0;
    dreq_wdata  = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_select", mem_select, 1'b0);
    chk("rst_addr", mem_addr, 8'd0);
    chk("rst_wdata", mem_wdata, 8'd0);
    chk("rst_type", mem_memory_type, 2'd0);
    chk("rst_write", mem_write, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_port", resp_port, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 8'd0);
    chk("rst_resp_error", resp_error, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Single fetch, latency 4
    @(negedge clock);
    fetch_valid = 1'b1;
    fetch_addr  = 8'h10;
    wait_grant(gf, gd);
    chk("t1_grant_fetch", gf, 1'b1);
    @(negedge clock);
    chk("t1_select", mem_select, 1'b1);
    chk("t1_type", mem_memory_type, MemTypeCode);
    chk("t1_write", mem_write, 1'b0);
    chk("t1_addr", mem_addr, 8'h10);
    chk("t1_ready_once", fetch_ready, 1'b0);
    fetch_valid = 1'b0;
    wait_resp(sel);
    chk("t1_port", resp_port, 1'b0);
    chk("t1_rdata", resp_rdata, 8'hA5);
    chk("t1_error", resp_error, 1'b0);
    chk("t1_select_low", mem_select, 1'b0);
    @(negedge clock);
    chk("t1_valid_pulse", resp_valid, 1'b0);
    chk("t1_rdata_hold", resp_rdata, 8'hA5);

    // Store then load
    dreq_valid = 1'b1;
    dreq_write = 1'b1;
    dreq_code  = 1'b0;
    dreq_addr  = 8'h20;
    dreq_wdata = 8'h5C;
    wait_grant(gf, gd);
    chk("t2_grant_store", gd, 1'b1);
    @(negedge clock);
    chk("t2_write", mem_write, 1'b1);
    chk("t2_type", mem_memory_type, MemTypeData);
    chk("t2_wdata", mem_wdata, 8'h5C);
    chk("t2_ready_once", dreq_ready, 1'b0);
    dreq_valid = 1'b0;
    wait_resp(sel);
    chk("t2_store_port", resp_port, 1'b1);
    chk("t2_store_rdata", resp_rdata, 8'h00);
    chk("t2_store_error", resp_error, 1'b0);
    dreq_valid = 1'b1;
    dreq_write = 1'b0;
    wait_grant(gf, gd);
    chk("t2_grant_load", gd, 1'b1);
    dreq_valid = 1'b0;
    wait_resp(sel);
    chk("t2_load_rdata", resp_rdata, 8'h5C);
    chk("t2_load_port", resp_port, 1'b1);
    chk("t2_code_untouched", code_mem[8'h20], 8'h33);

    // Tie arbitration after reset: dreq, fetch, dreq, fetch
    pulse_reset();
    fetch_valid = 1'b1;
    fetch_addr  = 8'h10;
    dreq_valid  = 1'b1;
    dreq_write  = 1'b0;
    dreq_code   = 1'b0;
    dreq_addr   = 8'h20;
    for (int i = 0; i < 4; i++) begin
      wait_grant(gf, gd);
      chk("t3_grant", {gf, gd}, (i % 2 == 0) ? 2'b01 : 2'b10);
      wait_resp(sel);
      chk("t3_port", resp_port, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("t3_rdata", resp_rdata, (i % 2 == 0) ? 8'h5C : 8'hA5);
    end
    fetch_valid = 1'b0;
    dreq_valid  = 1'b0;

    // Dead responder: timeout after 15 select-high cycles
    dead = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 8'h10;
    wait_grant(gf, gd);
    fetch_valid = 1'b0;
    wait_resp(sel);
    chk("t4_select_cycles", sel, 15);
    chk("t4_error", resp_error, 1'b1);
    chk("t4_rdata", resp_rdata, 8'h00);
    chk("t4_port", resp_port, 1'b0);
    chk("t4_select_low", mem_select, 1'b0);
    dead = 1'b0;
    fetch_valid = 1'b1;
    #1;
    chk("t4_release_no_grant", fetch_ready, 1'b0);
    @(negedge clock);
    #1;
    chk("t4_idle_grant", fetch_ready, 1'b1);
    wait_grant(gf, gd);
    fetch_valid = 1'b0;
    wait_resp(sel);
    chk("t4_recover_error", resp_error, 1'b0);
    chk("t4_recover_rdata", resp_rdata, 8'hA5);

    // Sticky ready held after select drops
    latency     = 2;
    sticky_hold = 2;
    #1;
    base = resp_cnt;
    fetch_valid = 1'b1;
    wait_grant(gf, gd);
    fetch_valid = 1'b0;
    wait_resp(sel);
    dreq_valid = 1'b1;
    dreq_write = 1'b0;
    dreq_code  = 1'b0;
    dreq_addr  = 8'h20;
    #1;
    rdy_cycles = 0;
    bad = 0;
    while (mem_data_ready && rdy_cycles < 20) begin
      if (mem_select || dreq_ready) bad++;
      rdy_cycles++;
      @(negedge clock);
      #1;
    end
    chk("t5_ready_cycles", rdy_cycles, 3);
    chk("t5_no_select_while_ready", bad, 0);
    chk("t5_single_resp", resp_cnt - base, 1);
    wait_grant(gf, gd);
    chk("t5_next_grant", gd, 1'b1);
    dreq_valid = 1'b0;
    wait_resp(sel);
    chk("t5_next_rdata", resp_rdata, 8'h5C);
    #1;
    chk("t5_resp_total", resp_cnt - base, 2);
    latency     = 4;
    sticky_hold = 0;

    // Reset two cycles into ACCESS
    @(negedge clock);
    fetch_valid = 1'b1;
    fetch_addr  = 8'h10;
    wait_grant(gf, gd);
    fetch_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    base = resp_cnt;
    @(posedge clock);
    #1;
    chk("t6_select", mem_select, 1'b0);
    chk("t6_resp_valid", resp_valid, 1'b0);
    chk("t6_addr", mem_addr, 8'd0);
    chk("t6_type", mem_memory_type, 2'd0);
    chk("t6_rdata", resp_rdata, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    #1;
    chk("t6_no_resp", resp_cnt - base, 0);
    chk("t6_select_idle", mem_select, 1'b0);
    fetch_valid = 1'b1;
    wait_grant(gf, gd);
    chk("t6_regrant", gf, 1'b1);
    fetch_valid = 1'b0;
    wait_resp(sel);
    chk("t6_after_rdata", resp_rdata, 8'hA5);
    chk("t6_after_error", resp_error, 1'b0);

    @(negedge clock);
    chk("mon_both_grants", viol_both, 0);
    chk("mon_grant_busy", viol_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spell_mem_initiator.md
Name: spell_mem_initiator

Overview:
- Initiator (master) side of the spell memory bus; sits between the spell core and the memory responder.
- Arbitrates between an instruction-fetch port and a load/store port.
- Drives the select/addr/write/memory_type/data bus, waits for the responder's data_ready, returns read data, and releases the bus.
- Adds a bounded-wait timeout so a dead responder cannot hang the core.

Parameters:
TIMEOUT_CYCLES, 15, max cycles mem_select may stay high without mem_data_ready before the access is aborted; legal range 1..255.

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch request; must stay high with stable fetch_addr until fetch_ready
fetch_addr  in  8  code-space read address
fetch_ready  out  1  fetch request accepted this cycle
dreq_valid  in  1  load/store request; must stay high with stable fields until dreq_ready
dreq_write  in  1  1 = write, 0 = read
dreq_code  in  1  1 = code space, 0 = data space
dreq_addr  in  8  address
dreq_wdata  in  8  write data
dreq_ready  out  1  load/store request accepted this cycle
resp_valid  out  1  one-cycle pulse: access complete
resp_port  out  1  0 = fetch, 1 = load/store; valid with resp_valid
resp_rdata  out  8  read data; 0 for writes and errors
resp_error  out  1  access timed out; valid with resp_valid
mem_select  out  1  to responder select
mem_addr  out  8  to responder addr
mem_wdata  out  8  to responder data_in
mem_memory_type  out  2  to responder memory_type; uses the shared MemoryTypeData/MemoryTypeCode encodings
mem_write  out  1  to responder write
mem_rdata  in  8  from responder data_out
mem_data_ready  in  1  from responder data_ready

Behaviour:
- All outputs are registered.
- Reset values:
  - mem_select, mem_write, mem_addr, mem_wdata, mem_memory_type: 0
  - resp_valid, resp_port, resp_rdata, resp_error: 0
  - State: IDLE; timeout counter: 0; last_grant: fetch.
- fetch_ready and dreq_ready are combinational grants. They are high only in IDLE, and only for the winning valid port. At most one is high per cycle.
- Arbitration when both ports are valid in IDLE: grant the port that did not win the previous grant (round-robin on last_grant). The first tie after reset goes to load/store. A single valid port is granted immediately.
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE: on grant at edge k:
  - Latch addr, wdata, write and type. Fetch is always a code-space read with write=0.
  - mem_select=1 from cycle k+1; go to ACCESS; clear the timeout counter.
- ACCESS:
  - All mem_* outputs are held stable.
  - On the first edge with mem_data_ready=1:
    - Capture mem_rdata (for reads; 0 for writes) into resp_rdata.
    - Pulse resp_valid for exactly one cycle, with resp_error=0 and resp_port=granted port.
    - Drop mem_select and go to RELEASE.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT_CYCLES with no ready:
    - Drop mem_select.
    - Pulse resp_valid with resp_error=1 and resp_rdata=0.
    - Go to RELEASE.
- RELEASE:
  - mem_select stays 0.
  - Go to IDLE on the first edge where mem_data_ready=0. This guarantees the responder has cleared data_ready and reloaded its latency counter.
  - A timed-out access whose ready never rose passes straight through RELEASE in one cycle.
- Minimum bus turnaround is one cycle of select low between accesses. No new grant is issued before IDLE.
- resp_valid must never be asserted twice for one grant.
- Late ready after timeout is ignored; RELEASE absorbs it.
- Reset mid-access: at the reset edge mem_select drops to 0, no resp_valid is produced, any pending requests are discarded, and the FSM returns to IDLE.
- resp_rdata and resp_error hold their values until the next response; resp_valid is the only qualifier.
- mem_wdata is don't-care for reads; drive the latched value or 0, never X.

Test Plan:
- Single fetch, responder latency 4: fetch_valid, addr 0x10 (code mem[0x10]=0xA5) -> fetch_ready 1 cycle, mem_select high, mem_memory_type=Code, mem_write=0; resp_valid 1 cycle with resp_port=0, rdata=0xA5; select low, then ready seen low, then next grant possible.
- Store then load: dreq write data addr 0x20 wdata 0x5C -> resp_rdata=0, error=0; then dreq read data addr 0x20 -> resp_rdata=0x5C; code mem[0x20] unchanged.
- Simultaneous fetch and dreq valid for 4 accesses -> grants alternate dreq, fetch, dreq, fetch; each resp_port matches its grant; never two grants in flight.
- Dead responder (mem_data_ready tied 0), TIMEOUT_CYCLES=15 -> select high exactly 15 cycles, then resp_valid with error=1, rdata=0; FSM back in IDLE one cycle later.
- Sticky ready: responder holds data_ready high 3 cycles after select drops -> no new mem_select until mem_data_ready=0; exactly one resp_valid.
- Reset asserted 2 cycles into ACCESS -> mem_select 0 at the reset edge, no resp_valid, all outputs at reset values; the first access after reset completes normally.
